writeback_arbiter: RTL
======================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter NUM_WARPS, default WARPS_PER_CORE, number of warps tagged on results.
REQ-002 SHALL have parameter LD_FIFO_DEPTH, default 4, load-return buffer entries (power of two, >=2).
REQ-003 SHALL have parameter STARVE_LIMIT, default 3, max consecutive cycles a non-empty load FIFO loses arbitration.
REQ-004 SHALL have ports, one clock, reset synchronous and active-high:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_warp_id  in  WARP_ID_WIDTH  result warp
- alu_rd  in  REG_ADDR_WIDTH  destination register
- alu_reg_write  in  1  result writes register file
- alu_result  in  WARP_SIZE x DATA_WIDTH  per-lane data
- ld_valid  in  1  load return offered
- ld_ready  out  1  load FIFO can accept
- ld_warp_id  in  WARP_ID_WIDTH  load warp
- ld_rd  in  REG_ADDR_WIDTH  load destination
- ld_result  in  WARP_SIZE x DATA_WIDTH  load data
- wb_valid  out  1  writeback stage valid (RF write port and forwarding WB source)
- wb_warp_id  out  WARP_ID_WIDTH  writeback warp
- wb_rd  out  REG_ADDR_WIDTH  writeback register
- wb_reg_write  out  1  RF write enable
- wb_result  out  WARP_SIZE x DATA_WIDTH  writeback data
- perf_alu_wb  out  32  ALU writebacks count
- perf_ld_wb  out  32  load writebacks count
- perf_alu_stall  out  32  cycles alu_valid && !alu_ready

Function
REQ-005 SHALL accept a load return when ld_valid && ld_ready; ld_ready = FIFO not full (no same-cycle pop bypass when full).
REQ-006 SHALL grant the load FIFO head when FIFO non-empty AND (!alu_valid OR FIFO full OR starve_cnt == STARVE_LIMIT); otherwise grant ALU if alu_valid.
REQ-007 SHALL drive alu_ready = !fifo_grant (ALU has no buffer; alu_ready high when idle).
REQ-008 SHALL register the granted entry into wb_* the cycle after grant (latency 1 for ALU, >=1 for load); wb_valid low when nothing granted.
REQ-009 SHALL force wb_reg_write = 0 when the granted rd == 0; load entries otherwise write with wb_reg_write = 1.
REQ-010 SHALL increment starve_cnt each cycle FIFO non-empty and not granted; clear on FIFO grant or when empty; saturate at STARVE_LIMIT.
REQ-011 SHALL pop exactly one FIFO entry per FIFO grant; simultaneous push and pop in non-full state SHALL keep count unchanged.
REQ-012 SHALL wrap FIFO read/write pointers modulo LD_FIFO_DEPTH; order of load returns SHALL be preserved.
REQ-013 SHALL never emit two writebacks in one cycle nor drop or duplicate an accepted result.

Reset
REQ-014 SHALL on rst clear FIFO (count 0, pointers 0), starve_cnt 0, wb_valid 0, wb_reg_write 0, wb_warp_id/wb_rd/wb_result 0, perf counters 0.
REQ-015 SHALL during rst drive alu_ready 0 and ld_ready 0; reset mid-operation discards buffered loads.

Configuration
REQ-016 SHALL, with macro WB_PERF_COUNTERS_EN defined, implement perf counters as 32-bit saturating counters updated per REQ-004 meanings.
REQ-017 SHALL, without WB_PERF_COUNTERS_EN, keep perf ports and tie them to 0 with no counter flops.

Verification
REQ-018 ALU only: alu_valid=1, rd=5, warp=2 single cycle -> next cycle wb_valid=1, wb_rd=5, wb_warp_id=2, alu_ready=1.
REQ-019 rd zero: ALU rd=0, reg_write=1 -> wb_valid=1, wb_reg_write=0.
REQ-020 Starvation: alu_valid held high, one load pushed -> load appears on wb after STARVE_LIMIT=3 ALU writebacks; alu_ready=0 exactly in grant cycle.
REQ-021 Full FIFO: alu_valid held, 4 loads pushed -> ld_ready=0 at count 4, FIFO granted next, loads exit in push order.
REQ-022 Reset mid-stream: 2 loads buffered, rst pulsed -> wb_valid=0 next cycle, buffered loads never emitted, ld_ready=1 after release.
REQ-023 Perf: with WB_PERF_COUNTERS_EN, 10 ALU + 3 loads -> perf_alu_wb=10, perf_ld_wb=3; without macro all read 0.

Source files
------------

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: single writeback port shared by the ALU result path and a load-return FIFO, with a bounded wait for loads; ports alu_* and ld_* in, wb_* out, perf_* counters that are live only with WB_PERF_COUNTERS_EN and tied to 0 otherwise
module writeback_arbiter #(
  parameter int WARPS_PER_CORE = 4,
  parameter int NUM_WARPS = WARPS_PER_CORE,
  parameter int WARP_SIZE = 4,
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LD_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT = 3,
  localparam int WARP_ID_WIDTH = NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic alu_valid,
  output logic alu_ready,
  input  logic [WARP_ID_WIDTH-1:0] alu_warp_id,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic alu_reg_write,
  input  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] alu_result,
  input  logic ld_valid,
  output logic ld_ready,
  input  logic [WARP_ID_WIDTH-1:0] ld_warp_id,
  input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
  input  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] ld_result,
  output logic wb_valid,
  output logic [WARP_ID_WIDTH-1:0] wb_warp_id,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic wb_reg_write,
  output logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] wb_result,
  output logic [31:0] perf_alu_wb,
  output logic [31:0] perf_ld_wb,
  output logic [31:0] perf_alu_stall
);
  localparam int PW = $clog2(LD_FIFO_DEPTH);
  localparam int SW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [PW:0] FULL = (PW + 1)'(LD_FIFO_DEPTH);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] data_mem [LD_FIFO_DEPTH];
  logic [WARP_ID_WIDTH-1:0] warp_mem [LD_FIFO_DEPTH];
  logic [REG_ADDR_WIDTH-1:0] rd_mem [LD_FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [SW-1:0] starve_cnt;
  logic empty, full, fifo_grant, alu_grant, push;
  always_comb begin
    empty = count == '0;
    full = count == FULL;
    fifo_grant = !rst && !empty && (!alu_valid || full || starve_cnt == SLIM);
    alu_grant = !rst && !fifo_grant && alu_valid;
    push = ld_valid && ld_ready;
  end
  assign alu_ready = !rst && !fifo_grant;
  assign ld_ready = !rst && !full;
  always_ff @(posedge clk)
    if (push) begin
      data_mem[wr_ptr] <= ld_result;
      warp_mem[wr_ptr] <= ld_warp_id;
      rd_mem[wr_ptr] <= ld_rd;
    end
  always_ff @(posedge clk)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      starve_cnt <= '0;
      wb_valid <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_warp_id <= '0;
      wb_rd <= '0;
      wb_result <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_grant) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW + 1)'(push) - (PW + 1)'(fifo_grant);
      starve_cnt <= (empty || fifo_grant) ? '0 : starve_cnt == SLIM ? SLIM : starve_cnt + 1'b1;
      wb_valid <= fifo_grant || alu_grant;
      wb_reg_write <= fifo_grant ? rd_mem[rd_ptr] != '0 : alu_grant && alu_reg_write && alu_rd != '0;
      if (fifo_grant) begin
        wb_warp_id <= warp_mem[rd_ptr];
        wb_rd <= rd_mem[rd_ptr];
        wb_result <= data_mem[rd_ptr];
      end else if (alu_grant) begin
        wb_warp_id <= alu_warp_id;
        wb_rd <= alu_rd;
        wb_result <= alu_result;
      end
    end
`ifdef WB_PERF_COUNTERS_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_alu_wb <= '0;
      perf_ld_wb <= '0;
      perf_alu_stall <= '0;
    end else begin
      if (alu_grant && perf_alu_wb != '1) perf_alu_wb <= perf_alu_wb + 1'b1;
      if (fifo_grant && perf_ld_wb != '1) perf_ld_wb <= perf_ld_wb + 1'b1;
      if (alu_valid && !alu_ready && perf_alu_stall != '1) perf_alu_stall <= perf_alu_stall + 1'b1;
    end
`else
  assign perf_alu_wb = '0;
  assign perf_ld_wb = '0;
  assign perf_alu_stall = '0;
`endif
endmodule
